// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, format encoding and the decoded bundle.
package decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
   } fmt_e;

   localparam int FMT_W     = 6;
   localparam int FMT_R_BIT = 0;
   localparam int FMT_I_BIT = 1;
   localparam int FMT_S_BIT = 2;
   localparam int FMT_B_BIT = 3;
   localparam int FMT_U_BIT = 4;
   localparam int FMT_J_BIT = 5;

   // imm holds the canonical 32-bit sign-extended immediate; widening to XLEN happens later.
   typedef struct packed {
      logic [FMT_W-1:0] fmt;
      logic             illegal;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [31:0]      imm;
   } decoded_t;

   // Every legal opcode ends in 2'b11, so compressed encodings fall through to illegal.
   function automatic fmt_e classify(input logic [6:0] opcode);
      fmt_e f;
      case (opcode)
         OP_R:                                          f = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: f = FMT_I;
         OP_STORE:                                      f = FMT_S;
         OP_BRANCH:                                     f = FMT_B;
         OP_LUI, OP_AUIPC:                              f = FMT_U;
         OP_JAL:                                        f = FMT_J;
         default:                                       f = FMT_ILL;
      endcase
      return f;
   endfunction

   function automatic logic [FMT_W-1:0] fmt_onehot(input fmt_e f);
      logic [FMT_W-1:0] oh;
      oh = '0;
      case (f)
         FMT_R:   oh[FMT_R_BIT] = 1'b1;
         FMT_I:   oh[FMT_I_BIT] = 1'b1;
         FMT_S:   oh[FMT_S_BIT] = 1'b1;
         FMT_B:   oh[FMT_B_BIT] = 1'b1;
         FMT_U:   oh[FMT_U_BIT] = 1'b1;
         FMT_J:   oh[FMT_J_BIT] = 1'b1;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field extraction: instruction word to decoded_t plus XLEN-wide immediate.
module decode_fields
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output decoded_t        dec,
   output logic [XLEN-1:0] imm
);

   fmt_e        fmt;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign fmt   = classify(instr[6:0]);
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Fields a format does not define stay zero rather than carrying raw instruction bits.
   always_comb begin
      dec         = '0;
      dec.fmt     = fmt_onehot(fmt);
      dec.illegal = (fmt == FMT_ILL);
      case (fmt)
         FMT_R: begin
            dec.rd     = instr[11:7];
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.funct3 = instr[14:12];
            dec.funct7 = instr[31:25];
         end
         FMT_I: begin
            dec.rd     = instr[11:7];
            dec.rs1    = instr[19:15];
            dec.funct3 = instr[14:12];
            dec.imm    = imm_i;
         end
         FMT_S: begin
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.funct3 = instr[14:12];
            dec.imm    = imm_s;
         end
         FMT_B: begin
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.funct3 = instr[14:12];
            dec.imm    = imm_b;
         end
         FMT_U: begin
            dec.rd  = instr[11:7];
            dec.imm = imm_u;
         end
         FMT_J: begin
            dec.rd  = instr[11:7];
            dec.imm = imm_j;
         end
         default: dec = dec;
      endcase
   end

   assign imm = XLEN'($signed(dec.imm));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, backpressure and flush.
// Optional per-class transfer counters are enabled with `define DECODE_PERF_CNT_EN.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [5:0]      out_fmt,
   output logic            out_illegal,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]     cnt_r,
   output logic [31:0]     cnt_i,
   output logic [31:0]     cnt_s,
   output logic [31:0]     cnt_b,
   output logic [31:0]     cnt_u,
   output logic [31:0]     cnt_j,
   output logic [31:0]     cnt_ill
`endif
);

   // Handshake: a word moves on any edge where valid && ready; the register
   // refills in the same cycle it drains, giving one result per cycle.
   decoded_t        dec;
   logic [XLEN-1:0] dec_imm;
   logic            in_fire;
   logic            out_fire;
   logic            unused_canon_imm;

   decode_fields #(.XLEN(XLEN)) u_fields (
      .instr (in_instr),
      .dec   (dec),
      .imm   (dec_imm)
   );

   assign unused_canon_imm = ^dec.imm;
   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Data only loads on an accepted, unflushed word, so it is stable while held.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_pc      <= '0;
         out_fmt     <= '0;
         out_illegal <= 1'b0;
         out_rd      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_funct3  <= '0;
         out_funct7  <= '0;
         out_imm     <= '0;
      end else if (in_fire && !flush) begin
         out_pc      <= in_pc;
         out_fmt     <= dec.fmt;
         out_illegal <= dec.illegal;
         out_rd      <= dec.rd;
         out_rs1     <= dec.rs1;
         out_rs2     <= dec.rs2;
         out_funct3  <= dec.funct3;
         out_funct7  <= dec.funct7;
         out_imm     <= dec_imm;
      end
   end

`ifdef DECODE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= '0;
         cnt_i   <= '0;
         cnt_s   <= '0;
         cnt_b   <= '0;
         cnt_u   <= '0;
         cnt_j   <= '0;
         cnt_ill <= '0;
      end else if (out_fire) begin
         if (out_fmt[FMT_R_BIT]) cnt_r <= cnt_r + 32'd1;
         if (out_fmt[FMT_I_BIT]) cnt_i <= cnt_i + 32'd1;
         if (out_fmt[FMT_S_BIT]) cnt_s <= cnt_s + 32'd1;
         if (out_fmt[FMT_B_BIT]) cnt_b <= cnt_b + 32'd1;
         if (out_fmt[FMT_U_BIT]) cnt_u <= cnt_u + 32'd1;
         if (out_fmt[FMT_J_BIT]) cnt_j <= cnt_j + 32'd1;
         if (out_illegal)        cnt_ill <= cnt_ill + 32'd1;
      end
   end
`else
   logic unused_out_fire;
   assign unused_out_fire = out_fire;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I decode stage placed between fetch and execute. It accepts a 32-bit instruction plus its PC over a valid/ready handshake. It classifies the instruction format (R/I/S/B/U/J or illegal), extracts register fields, funct3/funct7 and the sign-extended immediate, and presents them one cycle later through an output pipeline register with backpressure and flush.

Parameters:
XLEN, 32, width of PC passthrough and immediate; immediate sign-extended to XLEN (legal: 32, 64)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard held and incoming instruction
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded result valid
out_ready  in  1  downstream accepts result
out_pc  out  XLEN  registered PC
out_fmt  out  6  one-hot {is_j,is_u,is_b,is_s,is_i,is_r}
out_illegal  out  1  unrecognised or non-32-bit encoding
out_rd  out  5  destination register (0 for S/B)
out_rs1  out  5  source 1 (0 for U/J)
out_rs2  out  5  source 2 (0 unless R/S/B)
out_funct3  out  3  instr[14:12] (0 for U/J)
out_funct7  out  7  instr[31:25] for R, else 0
out_imm  out  XLEN  sign-extended immediate, 0 for R and illegal

Behaviour:
- Reset (rst=1 at edge): out_valid=0; every data output=0; reset overrides flush and in_valid.
- in_ready = !out_valid || out_ready (combinational). Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N; throughput 1/cycle with out_ready held high.
- Holding: while out_valid && !out_ready, all out_* stay stable. in_ready=0.
- Flush: at the next edge, out_valid=0 and any same-cycle input is dropped. Data outputs may hold stale values but are don't-care while out_valid=0.
- Opcode map (instr[6:0]):
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else, or instr[1:0]!=2'b11: out_illegal=1 and out_fmt=0.
- Exactly one of out_fmt/out_illegal is set per valid output.
- Immediates, each sign-extended from instr[31]:
  - I = instr[31:20].
  - S = {instr[31:25],instr[11:7]}.
  - B = {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U = {instr[31:12],12'b0}.
  - J = {instr[31],instr[19:12],instr[20],instr[30:21],0}.
- Fields not defined by the format are driven to 0 (see Ports), not raw bits.

Optional Feature:
DECODE_PERF_CNT_EN:
- Defined: adds outputs cnt_r, cnt_i, cnt_s, cnt_b, cnt_u, cnt_j, cnt_ill (32 bits each).
  - Each counter increments by 1 on every output transfer of that class.
  - Counters wrap at 2^32-1 → 0.
  - Counters reset to 0 on rst. Flush does not clear them, and flushed instructions are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package decode_pkg:
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL).
  - fmt_e enum and bit indices for out_fmt.
  - Struct decoded_t bundling fmt, illegal, regs, functs, imm.
- Sub-module decode_fields: purely combinational instr→decoded_t, parametrised by XLEN. decode_stage owns only the handshake, pipeline register and optional counters.

Test Plan:
- addi x1,x2,5 (0x00510093), out_ready=1 → next cycle out_valid=1, fmt=is_i, rd=1, rs1=2, funct3=0, imm=5.
- sw x5,-4(x2) (0xFE512E23) → is_s, rs1=2, rs2=5, funct3=2, rd=0, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC).
- lui x3,0x12345 (0x123451B7) then 0x00000000 → first is_u, rd=3, imm=0x12345000; second out_illegal=1, fmt=0, imm=0.
- Backpressure: send addi, hold out_ready=0 for 3 cycles while in_valid=1 with a new word → in_ready=0, outputs stable. On release, both instructions emerge in order, none lost or duplicated.
- Flush: out_valid=1 holding jal, assert flush with in_valid=1 → next cycle out_valid=0 and the incoming word is never emitted. Assert rst mid-stream → all outputs 0 next cycle.
- With DECODE_PERF_CNT_EN: 10 random instructions, including 2 flushed → counters sum to 8 and match a reference model.
